mem_arbiter: RTL

- Shared main-memory port arbiter between the I-cache fill FSM, the D-cache fill FSM and the D-cache write-through store path.
- Sits directly downstream of both cache fill FSMs and directly upstream of the single multi-cycle main memory.
- Grants one requester at a time and generates the burst of word addresses for a block fill.
- Routes returning memory data-valid strobes back to the granted fill FSM.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and status signals around the main-memory arbiter.
// The arbiter attaches through the slave modport; requesters/memory (or a bench) use master.
interface mem_arbiter_if #(
  parameter int WBITS = 3
);
  logic             i_req;
  logic [15:0]      i_addr;
  logic             i_data_valid;
  logic             i_done;
  logic             d_req;
  logic [15:0]      d_addr;
  logic             d_data_valid;
  logic             d_done;
  logic             d_wr_req;
  logic [15:0]      d_wr_addr;
  logic [15:0]      d_wr_data;
  logic             d_wr_ack;
  logic [WBITS-1:0] fill_word;
  logic             mem_en;
  logic             mem_wr;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;
  logic             mem_rvalid;
  logic             busy;

  // mem_rdata goes straight to the caches, so the arbiter never sees it
  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data, mem_rvalid,
    output i_data_valid, i_done, d_data_valid, d_done, d_wr_ack, fill_word,
           mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
    input  i_data_valid, i_done, d_data_valid, d_done, d_wr_ack, fill_word,
           mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter: single-cycle stores, round-robin I/D block fills with
// burst address generation, and return-strobe routing back to the granted fill.
module mem_arbiter #(
  parameter int WORDS = 8,
  parameter int WBITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  localparam int BBITS = 16 - WBITS - 1;
  localparam logic [WBITS:0] LAST_ISSUE = (WBITS + 1)'(WORDS - 1);
  localparam logic [15:0]    BLK_MASK   = ~16'(2 * WORDS - 1);

  state_t           state;
  logic             grant;
  logic [BBITS-1:0] base;
  logic [WBITS:0]   issue_cnt;
  logic [WBITS:0]   issue_nxt;
  logic [WBITS-1:0] ret_cnt;
  logic             last_fill;

  logic             mem_en_q;
  logic             mem_wr_q;
  logic [15:0]      mem_addr_q;
  logic [15:0]      mem_wdata_q;
  logic             wr_ack_q;
  logic             busy_q;

  logic             pick_d;
  logic [15:0]      pick_addr;
  logic             in_burst;
  logic             ret_hit;
  logic             ret_last;

  always_comb begin
    pick_d    = bus.d_req && (!bus.i_req || !last_fill);
    pick_addr = pick_d ? bus.d_addr : bus.i_addr;
    in_burst  = (state == S_ISSUE) || (state == S_DRAIN);
    ret_hit   = in_burst && bus.mem_rvalid;
    ret_last  = ret_hit && (ret_cnt == '1);
    issue_nxt = issue_cnt + 1'b1;
  end

  // Memory-side outputs are registered one edge early, so each is already
  // correct during the cycle its state is occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= 1'b0;
      base        <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      last_fill   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      wr_ack_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.d_wr_req) begin
            state       <= S_WRITE;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= bus.d_wr_addr;
            mem_wdata_q <= bus.d_wr_data;
            wr_ack_q    <= 1'b1;
            busy_q      <= 1'b1;
          end else if (bus.i_req || bus.d_req) begin
            state      <= S_ISSUE;
            grant      <= pick_d;
            base       <= pick_addr[15:WBITS+1];
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            mem_en_q   <= 1'b1;
            mem_addr_q <= pick_addr & BLK_MASK;
            busy_q     <= 1'b1;
          end
        end
        S_WRITE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        S_ISSUE, S_DRAIN: begin
          if (ret_last) begin
            state     <= S_IDLE;
            last_fill <= grant;
            ret_cnt   <= '0;
            busy_q    <= 1'b0;
          end else begin
            if (ret_hit) ret_cnt <= ret_cnt + 1'b1;
            if (state == S_ISSUE) begin
              issue_cnt <= issue_nxt;
              if (issue_cnt == LAST_ISSUE) begin
                state <= S_DRAIN;
              end else begin
                mem_en_q   <= 1'b1;
                mem_addr_q <= {base, issue_nxt[WBITS-1:0], 1'b0};
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_en       = mem_en_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.d_wr_ack     = wr_ack_q;
  assign bus.busy         = busy_q;
  assign bus.fill_word    = ret_cnt;
  assign bus.i_data_valid = ret_hit && !grant;
  assign bus.d_data_valid = ret_hit && grant;
  assign bus.i_done       = ret_last && !grant;
  assign bus.d_done       = ret_last && grant;

endmodule
